// File: rtl/instr_mem_sync.sv
`default_nettype none
// ============================================================================
// Module  : instr_mem_sync
// Brief   : Synchronous instruction RAM for the IF stage with a registered
//           fetch port, stall/flush handling and a word-write programming port.
// Revision: 1.0 - initial release
// ============================================================================
module instr_mem_sync #(
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 1024,
    parameter int                ADDR_W   = 32,
    parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] address,
    input  logic              fetch_en,
    input  logic              stall,
    input  logic              flush,
    input  logic              prog_en,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [DATA_W-1:0] instruction,
    output logic              instr_valid,
    output logic              addr_err,
    output logic              prog_busy
);

    localparam int              IDX_W      = $clog2(DEPTH);
    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(4 * DEPTH);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_PROG = 1'b1;

    logic [0:0]        state;
    logic [0:0]        state_next;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [IDX_W-1:0]  fetch_idx;
    logic [IDX_W-1:0]  prog_idx;
    logic              fetch_ok;
    logic              prog_ok;

    logic              take_fetch;
    logic              load_nop;
    logic              clr_valid;
    logic              clr_err;
    logic              mem_we;

    assign fetch_idx = address[IDX_W+1:2];
    assign prog_idx  = prog_addr[IDX_W+1:2];
    assign fetch_ok  = ({1'b0, address} < ADDR_LIMIT) && (address[1:0] == 2'b00);
    assign prog_ok   = ({1'b0, prog_addr} < ADDR_LIMIT) && (prog_addr[1:0] == 2'b00);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_RUN:  if (prog_en)  state_next = ST_PROG;
            ST_PROG: if (!prog_en) state_next = ST_RUN;
            default: state_next = ST_RUN;
        endcase
    end

    // Entering PROG and flush both blank the fetch register; only flush also clears the error.
    always_comb begin
        take_fetch = 1'b0;
        load_nop   = 1'b0;
        clr_valid  = 1'b0;
        clr_err    = 1'b0;
        mem_we     = 1'b0;
        case (state)
            ST_RUN: begin
                if (prog_en) begin
                    load_nop  = 1'b1;
                    clr_valid = 1'b1;
                end else if (flush) begin
                    load_nop  = 1'b1;
                    clr_valid = 1'b1;
                    clr_err   = 1'b1;
                end else if (stall) begin
                    take_fetch = 1'b0;
                end else if (fetch_en) begin
                    take_fetch = 1'b1;
                end else begin
                    clr_valid = 1'b1;
                end
            end
            ST_PROG: begin
                clr_valid = 1'b1;
                mem_we    = prog_we && prog_ok;
            end
            default: begin
                clr_valid = 1'b1;
            end
        endcase
    end

    assign prog_busy = (state == ST_PROG);

    always_ff @(posedge clk) begin
        if (!rst) begin
            instruction <= NOP_WORD;
            instr_valid <= 1'b0;
            addr_err    <= 1'b0;
        end else if (take_fetch) begin
            instruction <= fetch_ok ? mem[fetch_idx] : NOP_WORD;
            instr_valid <= 1'b1;
            addr_err    <= !fetch_ok;
        end else begin
            if (load_nop)  instruction <= NOP_WORD;
            if (clr_valid) instr_valid <= 1'b0;
            if (clr_err)   addr_err    <= 1'b0;
        end
    end

    // Array has no reset so contents survive a reset; the reset cycle itself never writes.
    always_ff @(posedge clk) begin
        if (rst && mem_we) begin
            mem[prog_idx] <= prog_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_sync.sv
`default_nettype none
// ============================================================================
// Module  : tb_instr_mem_sync
// Brief   : Scoreboard bench for instr_mem_sync (reset, program, stall, flush,
//           address errors, PROG entry and reset during programming).
// Revision: 1.0 - initial release
// ============================================================================
module tb_instr_mem_sync;

    localparam int          DATA_W = 32;
    localparam int          DEPTH  = 16;
    localparam int          ADDR_W = 32;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic [31:0] address;
    logic        fetch_en;
    logic        stall;
    logic        flush;
    logic        prog_en;
    logic        prog_we;
    logic [31:0] prog_addr;
    logic [31:0] prog_data;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        addr_err;
    logic        prog_busy;

    instr_mem_sync #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .NOP_WORD (NOP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .address     (address),
        .fetch_en    (fetch_en),
        .stall       (stall),
        .flush       (flush),
        .prog_en     (prog_en),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .addr_err    (addr_err),
        .prog_busy   (prog_busy)
    );

    typedef struct {
        logic        r;
        logic        fe;
        logic [31:0] a;
        logic        st;
        logic        fl;
        logic        pe;
        logic        we;
        logic [31:0] pa;
        logic [31:0] pd;
    } stim_t;

    typedef struct {
        logic [31:0] ins;
        logic        v;
        logic        e;
        logic        b;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;

    // Reference model state
    logic        m_prog = 1'b0;
    logic [31:0] m_ins  = NOP;
    logic        m_v    = 1'b0;
    logic        m_e    = 1'b0;
    logic [31:0] m_mem [DEPTH];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic stim_t mk(logic r, logic fe, logic [31:0] a, logic st, logic fl,
                                 logic pe, logic we, logic [31:0] pa, logic [31:0] pd);
        stim_t s;
        s.r = r; s.fe = fe; s.a = a; s.st = st; s.fl = fl;
        s.pe = pe; s.we = we; s.pa = pa; s.pd = pd;
        return s;
    endfunction

    function automatic logic in_rng(logic [31:0] a);
        return (a < 32'(4 * DEPTH)) && (a[1:0] == 2'b00);
    endfunction

    // Drive one cycle of stimulus and push the outputs expected after the next edge.
    task automatic apply(input stim_t s);
        exp_t x;
        rst = s.r; fetch_en = s.fe; address = s.a; stall = s.st; flush = s.fl;
        prog_en = s.pe; prog_we = s.we; prog_addr = s.pa; prog_data = s.pd;
        if (!s.r) begin
            m_prog = 1'b0; m_ins = NOP; m_v = 1'b0; m_e = 1'b0;
        end else if (m_prog) begin
            if (s.we && in_rng(s.pa)) m_mem[s.pa >> 2] = s.pd;
            m_v = 1'b0;
            if (!s.pe) m_prog = 1'b0;
        end else if (s.pe) begin
            m_prog = 1'b1; m_ins = NOP; m_v = 1'b0;
        end else if (s.fl) begin
            m_ins = NOP; m_v = 1'b0; m_e = 1'b0;
        end else if (s.st) begin
            m_v = m_v;
        end else if (s.fe) begin
            m_ins = in_rng(s.a) ? m_mem[s.a >> 2] : NOP;
            m_v = 1'b1;
            m_e = !in_rng(s.a);
        end else begin
            m_v = 1'b0;
        end
        x.ins = m_ins; x.v = m_v; x.e = m_e; x.b = m_prog;
        sb.push_back(x);
    endtask

    task automatic test_reset();
        stim_t st[$];
        exp_t  x;
        st.push_back(mk(0, 1, 0, 1, 1, 1, 1, 0, 32'h1111_1111));
        st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        foreach (st[i]) begin
            apply(st[i]);
            @(posedge clk); #1;
            x = sb.pop_front();
            checks++;
            if (instruction !== x.ins || instr_valid !== x.v || addr_err !== x.e || prog_busy !== x.b) begin
                errors++;
                $display("FAIL reset[%0d]: got ins=%h v=%b e=%b b=%b, expected ins=%h v=%b e=%b b=%b",
                         i, instruction, instr_valid, addr_err, prog_busy, x.ins, x.v, x.e, x.b);
            end
        end
        checks++;
        if (instruction !== NOP || prog_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_const: got ins=%h b=%b, expected ins=%h b=0", instruction, prog_busy, NOP);
        end
    endtask

    task automatic test_program();
        stim_t st[$];
        exp_t  x;
        st.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0));
        st.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0,  32'hE3A0_0014));
        st.push_back(mk(1, 0, 0, 0, 0, 1, 1, 4,  32'hE3A0_1A01));
        st.push_back(mk(1, 0, 0, 0, 0, 1, 1, 8,  32'hE3A0_2103));
        st.push_back(mk(1, 0, 0, 0, 0, 1, 1, 12, 32'hE1A0_0000));
        st.push_back(mk(1, 0, 0, 0, 0, 1, 1, 16, 32'h1111_1111));
        st.push_back(mk(1, 0, 0, 0, 0, 1, 1, 20, 32'h2222_2222));
        st.push_back(mk(1, 0, 0, 0, 0, 1, 1, 24, 32'h3333_3333));
        st.push_back(mk(1, 0, 0, 0, 0, 1, 1, 28, 32'h4444_4444));
        st.push_back(mk(1, 0, 0, 0, 0, 1, 1, 60, 32'h5555_AAAA));
        st.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
        st.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
        st.push_back(mk(1, 1, 4, 0, 0, 0, 0, 0, 0));
        st.push_back(mk(1, 1, 8, 0, 0, 0, 0, 0, 0));
        st.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        foreach (st[i]) begin
            apply(st[i]);
            @(posedge clk); #1;
            x = sb.pop_front();
            checks++;
            if (instruction !== x.ins || instr_valid !== x.v || addr_err !== x.e || prog_busy !== x.b) begin
                errors++;
                $display("FAIL program[%0d]: got ins=%h v=%b e=%b b=%b, expected ins=%h v=%b e=%b b=%b",
                         i, instruction, instr_valid, addr_err, prog_busy, x.ins, x.v, x.e, x.b);
            end
        end
        checks++;
        if (instruction !== 32'hE3A0_2103 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL program_hold: got ins=%h v=%b, expected ins=e3a02103 v=0", instruction, instr_valid);
        end
    endtask

    task automatic test_stall();
        stim_t st[$];
        exp_t  x;
        st.push_back(mk(1, 1, 12, 0, 0, 0, 0, 0, 0));
        st.push_back(mk(1, 1, 0,  1, 0, 0, 0, 0, 0));
        st.push_back(mk(1, 1, 0,  1, 0, 0, 0, 0, 0));
        st.push_back(mk(1, 0, 0,  1, 0, 0, 0, 0, 0));
        st.push_back(mk(1, 1, 4,  0, 0, 0, 0, 0, 0));
        st.push_back(mk(1, 1, 60, 0, 0, 0, 0, 0, 0));
        st.push_back(mk(1, 0, 0,  0, 0, 0, 0, 0, 0));
        foreach (st[i]) begin
            apply(st[i]);
            @(posedge clk); #1;
            x = sb.pop_front();
            checks++;
            if (instruction !== x.ins || instr_valid !== x.v || addr_err !== x.e || prog_busy !== x.b) begin
                errors++;
                $display("FAIL stall[%0d]: got ins=%h v=%b e=%b b=%b, expected ins=%h v=%b e=%b b=%b",
                         i, instruction, instr_valid, addr_err, prog_busy, x.ins, x.v, x.e, x.b);
            end
        end
    endtask

    task automatic test_flush();
        stim_t st[$];
        exp_t  x;
        st.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
        st.push_back(mk(1, 1, 4, 0, 1, 0, 0, 0, 0));
        st.push_back(mk(1, 1, 8, 0, 0, 0, 0, 0, 0));
        st.push_back(mk(1, 1, 4, 1, 1, 0, 0, 0, 0));
        st.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        foreach (st[i]) begin
            apply(st[i]);
            @(posedge clk); #1;
            x = sb.pop_front();
            checks++;
            if (instruction !== x.ins || instr_valid !== x.v || addr_err !== x.e || prog_busy !== x.b) begin
                errors++;
                $display("FAIL flush[%0d]: got ins=%h v=%b e=%b b=%b, expected ins=%h v=%b e=%b b=%b",
                         i, instruction, instr_valid, addr_err, prog_busy, x.ins, x.v, x.e, x.b);
            end
        end
    endtask

    task automatic test_addr_err();
        stim_t st[$];
        exp_t  x;
        st.push_back(mk(1, 1, 32'(4 * DEPTH), 0, 0, 0, 0, 0, 0));
        st.push_back(mk(1, 1, 2,              0, 0, 0, 0, 0, 0));
        st.push_back(mk(1, 1, 0,              1, 0, 0, 0, 0, 0));
        st.push_back(mk(1, 1, 0,              0, 0, 0, 0, 0, 0));
        st.push_back(mk(1, 1, 2,              0, 0, 0, 0, 0, 0));
        st.push_back(mk(1, 0, 0,              0, 1, 0, 0, 0, 0));
        st.push_back(mk(1, 1, 32'hFFFF_FFFC,  0, 0, 0, 0, 0, 0));
        st.push_back(mk(1, 1, 0,              0, 0, 0, 0, 0, 0));
        foreach (st[i]) begin
            apply(st[i]);
            @(posedge clk); #1;
            x = sb.pop_front();
            checks++;
            if (instruction !== x.ins || instr_valid !== x.v || addr_err !== x.e || prog_busy !== x.b) begin
                errors++;
                $display("FAIL addr_err[%0d]: got ins=%h v=%b e=%b b=%b, expected ins=%h v=%b e=%b b=%b",
                         i, instruction, instr_valid, addr_err, prog_busy, x.ins, x.v, x.e, x.b);
            end
        end
    endtask

    task automatic test_prog_entry();
        stim_t st[$];
        exp_t  x;
        st.push_back(mk(1, 1, 8, 0, 0, 0, 0, 0, 0));
        st.push_back(mk(1, 1, 0, 0, 0, 1, 0, 0, 0));
        st.push_back(mk(1, 1, 0, 0, 0, 1, 0, 0, 0));
        st.push_back(mk(1, 1, 0, 0, 0, 1, 1, 32'(4 * DEPTH), 32'hDEAD_BEEF));
        st.push_back(mk(1, 1, 0, 0, 0, 1, 1, 1, 32'hCAFE_F00D));
        st.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
        st.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
        st.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        foreach (st[i]) begin
            apply(st[i]);
            @(posedge clk); #1;
            x = sb.pop_front();
            checks++;
            if (instruction !== x.ins || instr_valid !== x.v || addr_err !== x.e || prog_busy !== x.b) begin
                errors++;
                $display("FAIL prog_entry[%0d]: got ins=%h v=%b e=%b b=%b, expected ins=%h v=%b e=%b b=%b",
                         i, instruction, instr_valid, addr_err, prog_busy, x.ins, x.v, x.e, x.b);
            end
        end
        checks++;
        if (instruction !== 32'hE3A0_0014) begin
            errors++;
            $display("FAIL prog_drop: got mem[0]=%h, expected e3a00014", instruction);
        end
    endtask

    task automatic test_reset_mid_prog();
        stim_t st[$];
        exp_t  x;
        st.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0,  0));
        st.push_back(mk(1, 0, 0, 0, 0, 1, 1, 16, 32'hA0A0_A0A0));
        st.push_back(mk(1, 0, 0, 0, 0, 1, 1, 20, 32'hB1B1_B1B1));
        st.push_back(mk(0, 0, 0, 0, 0, 1, 1, 24, 32'hC2C2_C2C2));
        st.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,  0));
        st.push_back(mk(1, 1, 16, 0, 0, 0, 0, 0, 0));
        st.push_back(mk(1, 1, 20, 0, 0, 0, 0, 0, 0));
        st.push_back(mk(1, 1, 24, 0, 0, 0, 0, 0, 0));
        st.push_back(mk(1, 1, 28, 0, 0, 0, 0, 0, 0));
        st.push_back(mk(1, 0, 0,  0, 0, 0, 0, 0, 0));
        foreach (st[i]) begin
            apply(st[i]);
            @(posedge clk); #1;
            x = sb.pop_front();
            checks++;
            if (instruction !== x.ins || instr_valid !== x.v || addr_err !== x.e || prog_busy !== x.b) begin
                errors++;
                $display("FAIL reset_mid_prog[%0d]: got ins=%h v=%b e=%b b=%b, expected ins=%h v=%b e=%b b=%b",
                         i, instruction, instr_valid, addr_err, prog_busy, x.ins, x.v, x.e, x.b);
            end
        end
        checks++;
        if (instruction !== 32'h4444_4444) begin
            errors++;
            $display("FAIL reset_mid_prog_keep: got ins=%h, expected 44444444", instruction);
        end
    endtask

    initial begin
        rst = 1'b0; fetch_en = 1'b0; address = '0; stall = 1'b0; flush = 1'b0;
        prog_en = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        test_reset();
        test_program();
        test_stall();
        test_flush();
        test_addr_err();
        test_prog_entry();
        test_reset_mid_prog();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
